// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two pipes share one register-file write port through one-entry buffers.
// Define REGFILE_WB_ARB_ROUND_ROBIN_EN for round-robin conflict resolution (default: A wins).
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic [1:0]        pend_cnt
);

    logic              buf_a_valid_q, buf_b_valid_q;
    logic [ADDR_W-1:0] buf_a_reg_q, buf_b_reg_q;
    logic [DATA_W-1:0] buf_a_data_q, buf_b_data_q;
    logic              reg_write_q;
    logic [ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0] write_data_q;
    logic              prefer_a;
    logic              grant_a, grant_b;
    logic              accept_a, accept_b;

`ifdef REGFILE_WB_ARB_ROUND_ROBIN_EN
    logic rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else if (grant_a) begin
            rr_ptr_q <= 1'b1;
        end else if (grant_b) begin
            rr_ptr_q <= 1'b0;
        end
    end

    assign prefer_a = !rr_ptr_q;
`else
    assign prefer_a = 1'b1;
`endif

    // Same destination always retires A first so B's (younger) value lands last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (buf_a_valid_q && buf_b_valid_q) begin
            if (buf_a_reg_q == buf_b_reg_q || prefer_a) begin
                grant_a = 1'b1;
            end else begin
                grant_b = 1'b1;
            end
        end else begin
            grant_a = buf_a_valid_q;
            grant_b = buf_b_valid_q;
        end
    end

    assign a_ready  = !buf_a_valid_q || grant_a;
    assign b_ready  = !buf_b_valid_q || grant_b;
    assign accept_a = a_valid && a_ready;
    assign accept_b = b_valid && b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_a_valid_q <= 1'b0;
            buf_b_valid_q <= 1'b0;
            buf_a_reg_q   <= '0;
            buf_b_reg_q   <= '0;
            buf_a_data_q  <= '0;
            buf_b_data_q  <= '0;
            reg_write_q   <= 1'b0;
            write_reg_q   <= '0;
            write_data_q  <= '0;
        end else begin
            // Writes to x0 complete the handshake but never occupy the buffer.
            if (accept_a) begin
                buf_a_valid_q <= (a_reg != '0);
                buf_a_reg_q   <= a_reg;
                buf_a_data_q  <= a_data;
            end else if (grant_a) begin
                buf_a_valid_q <= 1'b0;
            end
            if (accept_b) begin
                buf_b_valid_q <= (b_reg != '0);
                buf_b_reg_q   <= b_reg;
                buf_b_data_q  <= b_data;
            end else if (grant_b) begin
                buf_b_valid_q <= 1'b0;
            end
            reg_write_q <= grant_a || grant_b;
            if (grant_a) begin
                write_reg_q  <= buf_a_reg_q;
                write_data_q <= buf_a_data_q;
            end else if (grant_b) begin
                write_reg_q  <= buf_b_reg_q;
                write_data_q <= buf_b_data_q;
            end
        end
    end

    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign pend_cnt   = {1'b0, buf_a_valid_q} + {1'b0, buf_b_valid_q};

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, corner sequences and
// randomized traffic against a slot-based reference model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [1:0]  pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .write_data(write_data),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: slot 0 = pipe A, slot 1 = pipe B.
    bit          mv[2];
    logic [4:0]  mr[2];
    logic [31:0] md[2];
    bit          mrr;
    bit          m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic [4:0]  wlog[$];

    function automatic int winner();
        if (!mv[0] && !mv[1]) return -1;
        if (!mv[1]) return 0;
        if (!mv[0]) return 1;
        if (mr[0] == mr[1]) return 0;
`ifdef REGFILE_WB_ARB_ROUND_ROBIN_EN
        return mrr ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic [41:0] model_vec();
        int w = winner();
        logic [1:0] pc = 2'(int'(mv[0]) + int'(mv[1]));
        return {m_we, m_wreg, m_wdata, logic'(!mv[0] || w == 0), logic'(!mv[1] || w == 1), pc};
    endfunction

    function automatic logic [41:0] dut_vec();
        return {reg_write, write_reg, write_data, a_ready, b_ready, pend_cnt};
    endfunction

    task automatic model_edge(input logic r, input logic av, input logic [4:0] ar,
                              input logic [31:0] ad, input logic bv, input logic [4:0] br,
                              input logic [31:0] bd);
        int w = winner();
        if (r) begin
            mv[0] = 0; mv[1] = 0; mrr = 0;
            m_we = 0; m_wreg = '0; m_wdata = '0;
            return;
        end
        if (w >= 0) begin
            m_we = 1; m_wreg = mr[w]; m_wdata = md[w];
            mv[w] = 0;
            mrr = (w == 0);
        end else begin
            m_we = 0;
        end
        // A slot that is empty after retirement can take a new result.
        if (av && !mv[0]) begin mv[0] = (ar != 0); mr[0] = ar; md[0] = ad; end
        if (bv && !mv[1]) begin mv[1] = (br != 0); mr[1] = br; md[1] = bd; end
    endtask

    task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got we=%0b reg=%0d data=%h ar=%0b br=%0b pend=%0d, want we=%0b reg=%0d data=%h ar=%0b br=%0b pend=%0d",
                     nm, act[41], act[40:36], act[35:4], act[3], act[2], act[1:0],
                     exp[41], exp[40:36], exp[35:4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, compare after the rising edge.
    task automatic cycle(input string nm, input logic r, input logic av, input logic [4:0] ar,
                         input logic [31:0] ad, input logic bv, input logic [4:0] br,
                         input logic [31:0] bd);
        rst = r; a_valid = av; a_reg = ar; a_data = ad; b_valid = bv; b_reg = br; b_data = bd;
        model_edge(r, av, ar, ad, bv, br, bd);
        @(posedge clk);
        @(negedge clk);
        chk(nm, dut_vec(), model_vec());
        if (reg_write === 1'b1) wlog.push_back(write_reg);
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++) cycle(nm, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    typedef struct packed {
        logic        r;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic [41:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic        oav, obv;
        logic [4:0]  oar, obr;
        logic [31:0] oad, obd;
        bit          ra, rb, rr;
        int          nb;

        // Expected: {we, wreg, wdata, a_ready, b_ready, pend} after the edge.
        tbl[0] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                   {1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 2'd0}};
        tbl[1] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,
                   {1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 2'd1}};
        tbl[2] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                   {1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 2'd0}};
        tbl[3] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                   {1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 2'd0}};
        tbl[4] = '{1'b0, 1'b1, 5'd10, 32'hCAFEBABE, 1'b1, 5'd10, 32'h12345678,
                   {1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 2'd2}};
        tbl[5] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                   {1'b1, 5'd10, 32'hCAFEBABE, 1'b1, 1'b1, 2'd1}};
        tbl[6] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                   {1'b1, 5'd10, 32'h12345678, 1'b1, 1'b1, 2'd0}};
        tbl[7] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                   {1'b0, 5'd10, 32'h12345678, 1'b1, 1'b1, 2'd0}};
        tbl[8] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h12345678,
                   {1'b0, 5'd10, 32'h12345678, 1'b1, 1'b1, 2'd0}};
        tbl[9] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                   {1'b0, 5'd10, 32'h12345678, 1'b1, 1'b1, 2'd0}};

        for (int i = 0; i < 10; i++) begin
            cycle($sformatf("vec%0d_model", i), tbl[i].r, tbl[i].av, tbl[i].ar, tbl[i].ad,
                  tbl[i].bv, tbl[i].br, tbl[i].bd);
            chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // Contention: both pipes offer distinct regs every cycle; offers held until taken.
        wlog.delete();
        oar = 5'd1; obr = 5'd16;
        for (int i = 0; i < 6; i++) begin
            ra = !mv[0] || winner() == 0;
            rb = !mv[1] || winner() == 1;
            cycle("contend", 1'b0, 1'b1, oar, {27'd0, oar}, 1'b1, obr, {27'd0, obr});
            if (ra) oar = oar + 5'd1;
            if (rb) obr = obr + 5'd1;
        end
        chk_int("contend_nwrites", wlog.size(), 5);
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
`ifdef REGFILE_WB_ARB_ROUND_ROBIN_EN
            chk_int($sformatf("contend_src%0d", i), int'(wlog[i] >= 16), i % 2);
`else
            chk_int($sformatf("contend_src%0d", i), int'(wlog[i] >= 16), 0);
`endif
        end
        idle("contend_drain", 4);

        // Streaming: A alone, regs 1..4 back to back.
        wlog.delete();
        for (int i = 1; i <= 4; i++) begin
            cycle("stream", 1'b0, 1'b1, 5'(i), 32'(i * 3), 1'b0, 5'd0, 32'd0);
            chk_int("stream_aready", int'(a_ready), 1);
        end
        idle("stream_drain", 3);
        chk_int("stream_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk_int($sformatf("stream_reg%0d", i), int'(wlog[i]), i + 1);

        // Reset with both buffers full: pending writes must vanish.
        wlog.delete();
        cycle("rst_fill", 1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
        chk_int("rst_fill_pend", int'(pend_cnt), 2);
        cycle("rst_mid", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("rst_mid_state", dut_vec(), {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'd0});
        idle("rst_after", 3);
        chk_int("rst_no_writes", wlog.size(), 0);

        // Randomized traffic with occasional resets; small reg range forces conflicts.
        oav = 0; obv = 0; oar = 0; obr = 0; oad = 0; obd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!oav) begin
                oav = 1'($urandom_range(0, 1));
                oar = 5'($urandom_range(0, 6));
                oad = $urandom;
            end
            if (!obv) begin
                obv = 1'($urandom_range(0, 1));
                obr = 5'($urandom_range(0, 6));
                obd = $urandom;
            end
            rr = ($urandom_range(0, 63) == 0);
            ra = !mv[0] || winner() == 0;
            rb = !mv[1] || winner() == 1;
            cycle("random", rr, oav, oar, oad, obv, obr, obd);
            if (!rr && ra) oav = 0;
            if (!rr && rb) obv = 0;
        end
        nb = 0;
        while (pend_cnt != 0 && nb < 5) begin
            idle("random_drain", 1);
            nb++;
        end
        chk_int("random_drained", int'(pend_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port (reg_write / write_reg / write_data) between the two issue pipes of the dual-issue core. Each pipe hands its result over through a valid/ready handshake into a one-entry holding buffer. The arbiter retires at most one write per cycle to the register file through registered outputs, drops writes to x0, and preserves older-before-younger order when both pipes target the same register.

## Interface
- ADDR_W, 5, register index width
- DATA_W, 32, register data width

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a_valid  input  1  pipe A (older slot of issue pair) has a result
- a_ready  output  1  pipe A buffer can accept this cycle
- a_reg  input  ADDR_W  pipe A destination register
- a_data  input  DATA_W  pipe A result
- b_valid  input  1  pipe B (younger slot) has a result
- b_ready  output  1  pipe B buffer can accept this cycle
- b_reg  input  ADDR_W  pipe B destination register
- b_data  input  DATA_W  pipe B result
- reg_write  output  1  register file write enable (registered)
- write_reg  output  ADDR_W  register file write index (registered)
- write_data  output  DATA_W  register file write data (registered)
- pend_cnt  output  2  number of occupied holding buffers (0..2)

## Operation
- State: buf_a, buf_b (valid, reg, data each); rr_ptr (1 bit, 0 = A next); output register.
- Accept: x_valid && x_ready at an edge loads buf_x. If x_reg == 0, the transfer completes but buf_x stays empty (write dropped, never granted).
- x_ready = !buf_x.valid || grant_x. This is combinational from buffer state and grant, never from x_valid.
- Grant, combinational each cycle:
  - Only one buffer valid: grant it.
  - Both valid and buf_a.reg == buf_b.reg: grant A (older) first. B retires in a later cycle, so B's value is final.
  - Both valid, different regs: grant per policy (see Configuration).
  - Neither valid: no grant.
- On grant: the output register loads reg_write=1, write_reg, write_data from the granted buffer, and that buffer clears unless it is refilled the same edge. rr_ptr toggles to the other requester.
- No grant: reg_write=0 next cycle. write_reg/write_data hold their previous values.
- pend_cnt = buf_a.valid + buf_b.valid (combinational from state).

## Timing
- Reset (rst high at edge): buffers empty, rr_ptr=0, reg_write=0, write_reg=0, write_data=0, pend_cnt=0. Contents of any pending buffers are discarded.
- During the reset cycle a_ready/b_ready are 1 (buffers empty), but nothing is accepted while rst is high.
- Latency: accepted at end of cycle k → granted in cycle k+1 → reg_write high in cycle k+2.
- Throughput: one register-file write per cycle. A single pipe streaming alone sustains one result per cycle (drain and refill on the same edge).
- Simultaneous events:
  - Both pipes valid with empty buffers: both accepted at the same edge.
  - Next cycle, one is granted. The losing pipe's ready is 0 until its buffer drains.
- Starvation: bounded to 1 cycle under round-robin. Under fixed priority, bounded only by the same-reg rule.

## Configuration
- Macro: REGFILE_WB_ARB_ROUND_ROBIN_EN.
  - Defined: different-register conflicts are resolved by rr_ptr (alternating A/B).
  - Undefined: fixed priority, A always wins. rr_ptr logic is not compiled.
- The same-register rule (A before B) applies in both builds.

## Test plan
- Single write: reset, then a_valid=1, a_reg=5, a_data=DEADBEEF for 1 cycle → reg_write=1, write_reg=5, write_data=DEADBEEF exactly 2 cycles later, then reg_write=0; pend_cnt 1 for one cycle.
- Same-reg conflict: A and B valid together, both reg=10, A=CAFEBABE, B=12345678 → two consecutive writes: 10←CAFEBABE, then 10←12345678. b_ready=0 in the cycle A is granted.
- x0 drop: b_valid=1, b_reg=0, b_data=12345678 → b_ready=1, pend_cnt stays 0, reg_write never asserts.
- Back-to-back contention, distinct regs, both pipes valid every cycle for 6 cycles:
  - With macro: write_reg alternates A,B,A,B…
  - Without macro: A every cycle while B stalls (b_ready=0).
- Streaming: A alone valid 4 consecutive cycles, regs 1..4 → a_ready stays 1 and four consecutive reg_write pulses with regs 1,2,3,4.
- Reset mid-operation: both buffers full, rst high for 1 cycle → next cycle reg_write=0, pend_cnt=0, write_reg=0, write_data=0; discarded writes never appear.
